// File: rtl/csi2_packet_parser.sv
// CSI-2 single-lane packet parser: frames the received byte stream into packets,
// decodes the header, streams long-packet payload and checks the CRC-16 footer.
module csi2_packet_parser #(
  parameter int CHECK_CRC = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        enable,
  input  logic        lane_active,
  output logic        header_valid,
  output logic [1:0]  virtual_channel,
  output logic [5:0]  data_type,
  output logic [15:0] word_count,
  output logic [7:0]  ecc,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        packet_done,
  output logic        crc_error,
  output logic        packet_aborted
);

  typedef enum logic [1:0] {HEADER = 2'd0, PAYLOAD = 2'd1, FOOTER = 2'd2} state_t;

  // Reflected CRC-16 (0x8408), one byte shifted in LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, crc_lo_q, crc_lo_d;
  logic [15:0] crc_q, crc_d;

  logic        header_valid_q, header_valid_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  ecc_q, ecc_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic [7:0]  payload_data_q, payload_data_d;
  logic        payload_valid_q, payload_valid_d;
  logic        packet_done_q, packet_done_d;
  logic        crc_error_q, crc_error_d;
  logic        packet_aborted_q, packet_aborted_d;

  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  assign hdr_dt = b0_q[5:0];
  assign hdr_wc = {b2_q, b1_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= HEADER;
      idx_q            <= 2'd0;
      remaining_q      <= 16'd0;
      b0_q             <= 8'd0;
      b1_q             <= 8'd0;
      b2_q             <= 8'd0;
      crc_lo_q         <= 8'd0;
      header_valid_q   <= 1'b0;
      vc_q             <= 2'd0;
      dt_q             <= 6'd0;
      wc_q             <= 16'd0;
      ecc_q            <= 8'd0;
      fs_q             <= 1'b0;
      fe_q             <= 1'b0;
      ls_q             <= 1'b0;
      le_q             <= 1'b0;
      payload_data_q   <= 8'd0;
      payload_valid_q  <= 1'b0;
      packet_done_q    <= 1'b0;
      crc_error_q      <= 1'b0;
      packet_aborted_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      remaining_q      <= remaining_d;
      b0_q             <= b0_d;
      b1_q             <= b1_d;
      b2_q             <= b2_d;
      crc_lo_q         <= crc_lo_d;
      header_valid_q   <= header_valid_d;
      vc_q             <= vc_d;
      dt_q             <= dt_d;
      wc_q             <= wc_d;
      ecc_q            <= ecc_d;
      fs_q             <= fs_d;
      fe_q             <= fe_d;
      ls_q             <= ls_d;
      le_q             <= le_d;
      payload_data_q   <= payload_data_d;
      payload_valid_q  <= payload_valid_d;
      packet_done_q    <= packet_done_d;
      crc_error_q      <= crc_error_d;
      packet_aborted_q <= packet_aborted_d;
    end
  end

  generate
    if (CHECK_CRC != 0) begin : g_crc
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) crc_q <= 16'hFFFF;
        else        crc_q <= crc_d;
      end
    end else begin : g_no_crc
      assign crc_q = 16'hFFFF;
    end
  endgenerate

  // Next-state: framing position within the packet.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    if (!lane_active) begin
      state_d     = HEADER;
      idx_d       = 2'd0;
      remaining_d = 16'd0;
    end else if (enable) begin
      case (state_q)
        HEADER: begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (hdr_dt <= 6'h0F) begin
              state_d = HEADER;
            end else if (hdr_wc == 16'd0) begin
              state_d = FOOTER;
            end else begin
              state_d     = PAYLOAD;
              remaining_d = hdr_wc;
            end
          end
        end
        PAYLOAD: begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = FOOTER;
            idx_d   = 2'd0;
          end
        end
        FOOTER: begin
          if (idx_q == 2'd1) begin
            state_d = HEADER;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        default: begin
          state_d = HEADER;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Outputs and datapath: header capture, payload forward, CRC accumulate/compare.
  always_comb begin
    b0_d             = b0_q;
    b1_d             = b1_q;
    b2_d             = b2_q;
    crc_lo_d         = crc_lo_q;
    crc_d            = crc_q;
    header_valid_d   = 1'b0;
    vc_d             = vc_q;
    dt_d             = dt_q;
    wc_d             = wc_q;
    ecc_d            = ecc_q;
    fs_d             = 1'b0;
    fe_d             = 1'b0;
    ls_d             = 1'b0;
    le_d             = 1'b0;
    payload_data_d   = payload_data_q;
    payload_valid_d  = 1'b0;
    packet_done_d    = 1'b0;
    crc_error_d      = 1'b0;
    packet_aborted_d = 1'b0;
    if (!lane_active) begin
      packet_aborted_d = (state_q != HEADER) || (idx_q != 2'd0);
    end else if (enable) begin
      case (state_q)
        HEADER: begin
          case (idx_q)
            2'd0: b0_d = data;
            2'd1: b1_d = data;
            2'd2: b2_d = data;
            default: begin
              header_valid_d = 1'b1;
              vc_d           = b0_q[7:6];
              dt_d           = hdr_dt;
              wc_d           = hdr_wc;
              ecc_d          = data;
              crc_d          = 16'hFFFF;
              fs_d           = (hdr_dt == 6'h00);
              fe_d           = (hdr_dt == 6'h01);
              ls_d           = (hdr_dt == 6'h02);
              le_d           = (hdr_dt == 6'h03);
            end
          endcase
        end
        PAYLOAD: begin
          payload_valid_d = 1'b1;
          payload_data_d  = data;
          crc_d           = crc16_byte(crc_q, data);
        end
        FOOTER: begin
          if (idx_q == 2'd0) begin
            crc_lo_d = data;
          end else begin
            packet_done_d = 1'b1;
            crc_error_d   = (CHECK_CRC != 0) && ({data, crc_lo_q} != crc_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign header_valid    = header_valid_q;
  assign virtual_channel = vc_q;
  assign data_type       = dt_q;
  assign word_count      = wc_q;
  assign ecc             = ecc_q;
  assign frame_start     = fs_q;
  assign frame_end       = fe_q;
  assign line_start      = ls_q;
  assign line_end        = le_q;
  assign payload_data    = payload_data_q;
  assign payload_valid   = payload_valid_q;
  assign packet_done     = packet_done_q;
  assign crc_error       = crc_error_q;
  assign packet_aborted  = packet_aborted_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Directed bench for csi2_packet_parser: short/long packets, CRC, abort, enable gaps, reset.
`timescale 1ns/1ps
module tb_csi2_packet_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        enable = 1'b0;
  logic        lane_active = 1'b1;
  logic        header_valid;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic        frame_start, frame_end, line_start, line_end;
  logic [7:0]  payload_data;
  logic        payload_valid, packet_done, crc_error, packet_aborted;

  csi2_packet_parser #(.CHECK_CRC(1)) dut (
    .clock(clock), .reset(reset), .data(data), .enable(enable), .lane_active(lane_active),
    .header_valid(header_valid), .virtual_channel(virtual_channel), .data_type(data_type),
    .word_count(word_count), .ecc(ecc), .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end), .payload_data(payload_data),
    .payload_valid(payload_valid), .packet_done(packet_done), .crc_error(crc_error),
    .packet_aborted(packet_aborted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit gaps = 1'b0;

  // Event monitor: samples registered outputs 2ns after each rising edge.
  int hv_cnt, fs_cnt, fe_cnt, ls_cnt, le_cnt, pd_cnt, ab_cnt, err_cnt;
  logic [7:0] pq [$];
  always @(posedge clock) begin
    #2;
    if (header_valid)   hv_cnt++;
    if (frame_start)    fs_cnt++;
    if (frame_end)      fe_cnt++;
    if (line_start)     ls_cnt++;
    if (line_end)       le_cnt++;
    if (payload_valid)  pq.push_back(payload_data);
    if (packet_done)    pd_cnt++;
    if (packet_done && crc_error) err_cnt++;
    if (packet_aborted) ab_cnt++;
  end

  logic [7:0] pay [0:23] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                             8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                             8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  task automatic clear_mon();
    hv_cnt = 0; fs_cnt = 0; fe_cnt = 0; ls_cnt = 0; le_cnt = 0;
    pd_cnt = 0; ab_cnt = 0; err_cnt = 0;
    pq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      enable = 1'b0;
      data   = 8'h5A;
    end
  endtask

  task automatic put(input logic [7:0] b);
    if (gaps) idle($urandom_range(0, 2));
    @(negedge clock);
    data   = b;
    enable = 1'b1;
  endtask

  task automatic send_header(input logic [7:0] b0, input logic [15:0] wc, input logic [7:0] e);
    put(b0); put(wc[7:0]); put(wc[15:8]); put(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    checks++;
    if ({header_valid, virtual_channel, data_type, word_count, ecc, frame_start, frame_end,
         line_start, line_end, payload_data, payload_valid, packet_done, crc_error,
         packet_aborted} !== 49'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wc=%h dt=%h pv=%b pd=%b, required all zero",
               word_count, data_type, payload_valid, packet_done);
    end
    @(negedge clock);
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_short_fs();
    clear_mon();
    send_header(8'h00, 16'h0001, 8'h07);
    idle(3);
    checks++; if (hv_cnt !== 1) begin errors++; $display("FAIL fs_header_valid: got %0d required 1", hv_cnt); end
    checks++; if (data_type !== 6'h00) begin errors++; $display("FAIL fs_data_type: got %h required 00", data_type); end
    checks++; if (word_count !== 16'h0001) begin errors++; $display("FAIL fs_word_count: got %h required 0001", word_count); end
    checks++; if (ecc !== 8'h07) begin errors++; $display("FAIL fs_ecc: got %h required 07", ecc); end
    checks++; if (fs_cnt !== 1) begin errors++; $display("FAIL fs_pulse: got %0d required 1", fs_cnt); end
    checks++; if (pq.size() !== 0 || pd_cnt !== 0) begin
      errors++; $display("FAIL fs_no_payload: got pv=%0d pd=%0d required 0 0", pq.size(), pd_cnt);
    end
  endtask

  task automatic test_sync_types();
    int exp [4];
    for (int t = 1; t < 6; t++) begin
      clear_mon();
      send_header({2'b01, t[5:0]}, 16'h0010, 8'h00);
      idle(2);
      exp[0] = 0; exp[1] = (t == 1); exp[2] = (t == 2); exp[3] = (t == 3);
      checks++;
      if (hv_cnt !== 1 || fs_cnt !== exp[0] || fe_cnt !== exp[1] || ls_cnt !== exp[2] ||
          le_cnt !== exp[3] || virtual_channel !== 2'd1) begin
        errors++;
        $display("FAIL sync_dt%0d: got hv=%0d fs=%0d fe=%0d ls=%0d le=%0d vc=%0d required 1 %0d %0d %0d %0d vc=1",
                 t, hv_cnt, fs_cnt, fe_cnt, ls_cnt, le_cnt, virtual_channel,
                 exp[0], exp[1], exp[2], exp[3]);
      end
    end
  endtask

  task automatic test_long(input bit use_gaps, input bit corrupt, input int exp_err);
    logic [7:0] p [0:23];
    int bad = 0;
    for (int i = 0; i < 24; i++) p[i] = pay[i];
    if (corrupt) p[5] = 8'hB8;
    gaps = use_gaps;
    clear_mon();
    send_header(8'h2A, 16'h0018, 8'h11);
    for (int i = 0; i < 24; i++) put(p[i]);
    put(8'hF0); put(8'h00);
    gaps = 1'b0;
    idle(3);
    checks++; if (hv_cnt !== 1 || word_count !== 16'h0018 || data_type !== 6'h2A) begin
      errors++; $display("FAIL long_header: got hv=%0d wc=%h dt=%h required 1 0018 2A", hv_cnt, word_count, data_type);
    end
    checks++; if (pq.size() !== 24) begin
      errors++; $display("FAIL long_payload_count: got %0d required 24", pq.size());
    end else begin
      for (int i = 0; i < 24; i++) if (pq[i] !== p[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL long_payload_bytes: got %0d wrong bytes required 0", bad); end
    end
    checks++; if (pd_cnt !== 1) begin errors++; $display("FAIL long_done: got %0d required 1", pd_cnt); end
    checks++; if (err_cnt !== exp_err) begin
      errors++; $display("FAIL long_crc_error: got %0d required %0d (gaps=%0d corrupt=%0d)", err_cnt, exp_err, use_gaps, corrupt);
    end
  endtask

  task automatic test_zero_length();
    clear_mon();
    send_header(8'h2A, 16'h0000, 8'h00);
    put(8'hFF); put(8'hFF);
    idle(3);
    checks++; if (pq.size() !== 0) begin errors++; $display("FAIL zero_len_payload: got %0d required 0", pq.size()); end
    checks++; if (pd_cnt !== 1 || err_cnt !== 0) begin
      errors++; $display("FAIL zero_len_done: got pd=%0d err=%0d required 1 0", pd_cnt, err_cnt);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    // Lane drop while idle between packets is not an abort.
    @(negedge clock); enable = 1'b0; lane_active = 1'b0;
    @(negedge clock); lane_active = 1'b1;
    idle(2);
    checks++; if (ab_cnt !== 0) begin errors++; $display("FAIL abort_idle: got %0d required 0", ab_cnt); end
    send_header(8'h2A, 16'h0018, 8'h00);
    for (int i = 0; i < 10; i++) put(pay[i]);
    // Concurrent enable byte must be discarded.
    @(negedge clock); lane_active = 1'b0; enable = 1'b1; data = pay[10];
    @(negedge clock); enable = 1'b0;
    @(negedge clock); lane_active = 1'b1;
    idle(3);
    checks++; if (ab_cnt !== 1) begin errors++; $display("FAIL abort_pulse: got %0d required 1", ab_cnt); end
    checks++; if (pd_cnt !== 0 || pq.size() !== 10) begin
      errors++; $display("FAIL abort_payload: got pd=%0d pv=%0d required 0 10", pd_cnt, pq.size());
    end
    clear_mon();
    send_header(8'h02, 16'h0005, 8'h00);
    idle(3);
    checks++; if (ls_cnt !== 1 || word_count !== 16'h0005 || hv_cnt !== 1) begin
      errors++; $display("FAIL abort_recover: got ls=%0d wc=%h hv=%0d required 1 0005 1", ls_cnt, word_count, hv_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_header(8'h01, 16'h0000, 8'h00);
    send_header(8'h2A, 16'h0002, 8'h00);
    put(8'h12); put(8'h34);
    put(8'hAB); put(8'hCD);
    send_header(8'h03, 16'h0000, 8'h00);
    idle(3);
    checks++; if (hv_cnt !== 3 || fe_cnt !== 1 || le_cnt !== 1) begin
      errors++; $display("FAIL b2b_headers: got hv=%0d fe=%0d le=%0d required 3 1 1", hv_cnt, fe_cnt, le_cnt);
    end
    checks++; if (pq.size() !== 2 || pd_cnt !== 1 || err_cnt !== 1) begin
      errors++; $display("FAIL b2b_payload: got pv=%0d pd=%0d err=%0d required 2 1 1", pq.size(), pd_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    send_header(8'h2A, 16'h0018, 8'h00);
    for (int i = 0; i < 6; i++) put(pay[i]);
    @(negedge clock); enable = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({header_valid, virtual_channel, data_type, word_count, ecc, frame_start, frame_end,
         line_start, line_end, payload_data, payload_valid, packet_done, crc_error,
         packet_aborted} !== 49'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got wc=%h pd_data=%h pv=%b required all zero",
               word_count, payload_data, payload_valid);
    end
    idle(2);
    @(negedge clock); reset = 1'b1;
    clear_mon();
    send_header(8'h00, 16'h0003, 8'h00);
    idle(3);
    checks++; if (hv_cnt !== 1 || fs_cnt !== 1 || word_count !== 16'h0003 || pq.size() !== 0) begin
      errors++; $display("FAIL reset_mid_recover: got hv=%0d fs=%0d wc=%h pv=%0d required 1 1 0003 0",
                         hv_cnt, fs_cnt, word_count, pq.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_mon();
    test_reset();
    test_short_fs();
    test_sync_types();
    test_long(1'b0, 1'b0, 0);
    test_long(1'b0, 1'b1, 1);
    test_zero_length();
    test_abort();
    test_long(1'b1, 1'b0, 0);
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
